// File: rtl/sfq_toggle_monitor.sv
// Toggle-encoded SFQ pulse monitor: synchronizes the line, counts toggles with saturation,
// flags spacing violations and unknown samples, and offers a one-deep snapshot handshake.
module sfq_toggle_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MIN_GAP = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             pulse,
    output logic             lvl,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             viol,
    output logic             x_seen,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_count
);

    localparam bit                GapEn  = (MIN_GAP > 1);
    localparam int unsigned       GapW   = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GapW-1:0]   GapMax = GapW'(MIN_GAP);
    localparam logic [CNT_W-1:0]  CntMax = '1;

    typedef enum logic [0:0] {StIdle, StGuard} state_e;

    logic             s1_q, s1_d, s2_q, s3_q;
    logic             in_unknown;
    logic             edge_det;

    state_e           state_q, state_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             in_guard;
    logic             spacing_hit;

    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             viol_q, viol_d;
    logic             x_seen_q, x_seen_d;
    logic             sat;

    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] snap_count_q, snap_count_d;
    logic             snap_take;

    // An unknown sample holds s1 so it cannot fabricate an edge; constant 0 in synthesis.
    always_comb begin
        in_unknown = $isunknown(in);
        s1_d       = in_unknown ? s1_q : in;
    end

    // Synchronizer keeps tracking in during reset so a static level settles before release.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s1_q;
        s3_q <= s2_q;
    end

    assign edge_det = s2_q ^ s3_q;

    // Spacing FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Spacing FSM: next state.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        if (edge_det) begin
            if (GapEn) begin
                state_d = StGuard;
                gap_d   = GapW'(1);
            end else begin
                state_d = StIdle;
                gap_d   = '0;
            end
        end else if (clr) begin
            state_d = StIdle;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    gap_d = gap_q;
                end
                StGuard: begin
                    gap_d = gap_q + GapW'(1);
                    if (gap_d == GapMax) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    gap_d   = '0;
                end
            endcase
        end
    end

    // Spacing FSM: outputs. clr forces IDLE, so an edge coinciding with it is never a violation.
    always_comb begin
        in_guard    = (state_q == StGuard) && !clr;
        spacing_hit = edge_det && in_guard;
    end

    // Counter and sticky flags.
    always_comb begin
        sat        = (count_q == CntMax);
        pulse_d    = edge_det;
        count_d    = count_q;
        overflow_d = overflow_q;
        viol_d     = viol_q;
        x_seen_d   = x_seen_q;
        if (clr) begin
            count_d    = edge_det ? CNT_W'(1) : '0;
            overflow_d = 1'b0;
            viol_d     = 1'b0;
            x_seen_d   = 1'b0;
        end else if (edge_det) begin
            if (sat) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        viol_d   = viol_d | spacing_hit;
        x_seen_d = x_seen_d | in_unknown;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            viol_q     <= 1'b0;
            x_seen_q   <= 1'b0;
        end else begin
            pulse_q    <= pulse_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            viol_q     <= viol_d;
            x_seen_q   <= x_seen_d;
        end
    end

    // Snapshot: capture the pre-increment count; a req with ack recaptures without dropping valid.
    always_comb begin
        snap_take    = snap_req && (!snap_valid_q || snap_ack);
        snap_valid_d = snap_take || (snap_valid_q && !snap_ack);
        snap_count_d = snap_take ? count_q : snap_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_valid_q <= 1'b0;
            snap_count_q <= '0;
        end else begin
            snap_valid_q <= snap_valid_d;
            snap_count_q <= snap_count_d;
        end
    end

    assign pulse      = pulse_q;
    assign lvl        = s3_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign viol       = viol_q;
    assign x_seen     = x_seen_q;
    assign snap_valid = snap_valid_q;
    assign snap_count = snap_count_q;

endmodule

// File: tb/tb_sfq_toggle_monitor.sv
// Directed bench for sfq_toggle_monitor (CNT_W=4, MIN_GAP=3) with hand-computed expectations.
module tb_sfq_toggle_monitor;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       clr;
    logic       snap_req;
    logic       snap_ack;
    logic       pulse;
    logic       lvl;
    logic [3:0] count;
    logic       overflow;
    logic       viol;
    logic       x_seen;
    logic       snap_valid;
    logic [3:0] snap_count;

    int total = 0;
    int bad   = 0;

    sfq_toggle_monitor #(
        .CNT_W   (4),
        .MIN_GAP (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (din),
        .clr        (clr),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .pulse      (pulse),
        .lvl        (lvl),
        .count      (count),
        .overflow   (overflow),
        .viol       (viol),
        .x_seen     (x_seen),
        .snap_valid (snap_valid),
        .snap_count (snap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_wait(input int n);
        din = ~din;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic xv;
        logic cur;
        logic [31:0] exp_cnt;
        logic [31:0] exp_x;

        din      = 1'b1;
        rst_n    = 1'b0;
        clr      = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;

        // Reset with static in=1
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_pulse", pulse, 0);
        check("rst_snapv", snap_valid, 0);
        check("rst_flags", {overflow, viol, x_seen}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_nopulse", pulse, 0);
        end
        check("rst_lvl", lvl, 1);
        check("rst_count_after", count, 0);

        // Pulse latency, then spacing 4 and 2
        din = ~din;
        tick(); tick();
        check("pulse_early", pulse, 0);
        tick();
        check("pulse_n2", pulse, 1);
        check("cnt_1", count, 1);
        tick();
        check("pulse_one_cycle", pulse, 0);
        din = ~din;
        tick(); tick();
        din = ~din;
        tick();
        check("gap4_cnt", count, 2);
        check("gap4_noviol", viol, 0);
        tick(); tick();
        check("gap2_cnt", count, 3);
        check("gap2_viol", viol, 1);
        repeat (4) tick();

        // Saturation
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_count", count, 0);
        check("clr_viol", viol, 0);
        for (int i = 0; i < 16; i++) begin
            toggle_wait(5);
            if (i == 14) begin
                check("sat_cnt15", count, 15);
                check("sat_noovf_yet", overflow, 0);
            end
        end
        check("sat_count", count, 15);
        check("sat_ovf", overflow, 1);
        check("sat_noviol", viol, 0);

        // clr coincident with an edge, count=7 viol=1
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) toggle_wait(5);
        din = ~din;
        tick(); tick();
        din = ~din;
        repeat (5) tick();
        check("pre_clr_cnt", count, 7);
        check("pre_clr_viol", viol, 1);
        din = ~din;
        tick(); tick();
        clr = 1'b1;
        din = ~din;
        tick();
        clr = 1'b0;
        check("clr_edge_cnt", count, 1);
        check("clr_edge_viol", viol, 0);
        check("clr_edge_pulse", pulse, 1);
        check("clr_edge_ovf", overflow, 0);
        tick(); tick();
        check("clr_guard_cnt", count, 2);
        check("clr_guard_viol", viol, 1);
        repeat (4) tick();

        // Snapshot
        clr = 1'b1; tick(); clr = 1'b0;
        din = ~din;
        tick(); tick();
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        check("snap_preinc", snap_count, 0);
        check("snap_preinc_v", snap_valid, 1);
        check("snap_preinc_cnt", count, 1);
        snap_ack = 1'b1; tick(); snap_ack = 1'b0;
        check("snap_ack_v", snap_valid, 0);
        check("snap_ack_hold", snap_count, 0);
        for (int i = 0; i < 4; i++) toggle_wait(5);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        check("snap5_v", snap_valid, 1);
        check("snap5_cnt", snap_count, 5);
        toggle_wait(5);
        check("cnt6", count, 6);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        check("snap_ignored", snap_count, 5);
        check("snap_ignored_v", snap_valid, 1);
        toggle_wait(5);
        snap_req = 1'b1; snap_ack = 1'b1; tick(); snap_req = 1'b0; snap_ack = 1'b0;
        check("snap_recap", snap_count, 7);
        check("snap_recap_v", snap_valid, 1);
        snap_ack = 1'b1; tick(); snap_ack = 1'b0;
        check("snap_drop_v", snap_valid, 0);
        snap_ack = 1'b1; tick(); snap_ack = 1'b0;
        check("ack_idle_v", snap_valid, 0);
        check("ack_idle_cnt", snap_count, 7);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_keeps_cnt0", count, 0);
        check("clr_keeps_snapv", snap_valid, 1);
        check("clr_keeps_snapc", snap_count, 7);
        snap_ack = 1'b1; tick(); snap_ack = 1'b0;

        // Unknown sample between legal toggles
        xv  = 1'bx;
        cur = din;
        exp_x   = $isunknown(xv) ? 32'd1 : 32'd0;
        exp_cnt = (!$isunknown(xv) && (xv != cur)) ? 32'd2 : 32'd0;
        din = xv;
        tick();
        din = cur;
        repeat (5) tick();
        check("x_count", count, exp_cnt);
        check("x_seen", x_seen, exp_x);
        toggle_wait(5);
        check("x_then_legal", count, exp_cnt + 32'd1);

        // Reset mid-operation with a pending snapshot and an in-flight toggle
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        din = ~din;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_snapv", snap_valid, 0);
        check("midrst_snapc", snap_count, 0);
        check("midrst_pulse", pulse, 0);
        check("midrst_count", count, 0);
        check("midrst_xseen", x_seen, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_nopulse", pulse, 0);
        end
        check("midrst_count_after", count, 0);
        check("midrst_lvl", lvl, din);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
